// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with count, flags, flush and FWFT
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               synchronous empty of the FIFO (ignores wr_en/rd_en that cycle)
//   clr_err             synchronous clear of overflow/underflow (set wins)
//   wr_en, data_in      write request and write word
//   rd_en               read request (FWFT: pop of the head word)
//   data_out, rd_valid  read word and its qualifier
//   full, empty         count == DEPTH, count == 0
//   almost_full         count >= AFULL_TH
//   almost_empty        count <= AEMPTY_TH
//   count               occupancy 0..DEPTH
//   overflow, underflow sticky error flags

module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              clr_err,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              wr_acc;
    logic              rd_acc;

    // All status flags are decoded from the count register only, so there is
    // no combinational path from wr_en/rd_en to any flag.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign count        = count_q;

    // A write into a full FIFO is refused even if a read frees a slot in the
    // same cycle; a flush cycle accepts nothing.
    assign wr_acc = wr_en & ~full  & ~flush;
    assign rd_acc = rd_en & ~empty & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            // Explicit wrap so non-power-of-two depths work.
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (wr_acc && !rd_acc) begin
                count_q <= count_q + CNT_W'(1);
            end else if (rd_acc && !wr_acc) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Sticky errors: a set in the same cycle as clr_err wins. Requests during a
    // flush cycle are ignored and so cannot set an error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (!flush && wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (!flush && rd_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; zero while empty so the reset
            // value of data_out is 0.
            assign data_out = empty ? '0 : mem[rd_ptr];
            assign rd_valid = ~empty;
        end else begin : g_std
            logic [DATA_W-1:0] dout_q;
            logic              valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_acc;
                    if (rd_acc) begin
                        dout_q <= mem[rd_ptr];
                    end
                end
            end

            assign data_out = dout_q;
            assign rd_valid = valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed bench for sync_fifo_param (std, DEPTH=6, FWFT instances)

module tb_sync_fifo_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Instance A: DATA_W=8, DEPTH=8, FWFT=0
    logic       a_flush = 0, a_clr = 0, a_wr = 0, a_rd = 0;
    logic [7:0] a_din = 0, a_dout;
    logic       a_rv, a_full, a_empty, a_af, a_ae, a_ov, a_un;
    logic [3:0] a_cnt;

    // Instance B: DEPTH=6, FWFT=0
    logic       b_flush = 0, b_clr = 0, b_wr = 0, b_rd = 0;
    logic [7:0] b_din = 0, b_dout;
    logic       b_rv, b_full, b_empty, b_af, b_ae, b_ov, b_un;
    logic [2:0] b_cnt;

    // Instance C: DEPTH=4, FWFT=1
    logic       c_flush = 0, c_clr = 0, c_wr = 0, c_rd = 0;
    logic [7:0] c_din = 0, c_dout;
    logic       c_rv, c_full, c_empty, c_af, c_ae, c_ov, c_un;
    logic [2:0] c_cnt;

    sync_fifo_param #(.DATA_W(8), .DEPTH(8), .FWFT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .clr_err(a_clr),
        .wr_en(a_wr), .data_in(a_din), .rd_en(a_rd),
        .data_out(a_dout), .rd_valid(a_rv), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt),
        .overflow(a_ov), .underflow(a_un)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(6), .FWFT(0)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .clr_err(b_clr),
        .wr_en(b_wr), .data_in(b_din), .rd_en(b_rd),
        .data_out(b_dout), .rd_valid(b_rv), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt),
        .overflow(b_ov), .underflow(b_un)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(4), .FWFT(1)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(c_flush), .clr_err(c_clr),
        .wr_en(c_wr), .data_in(c_din), .rd_en(c_rd),
        .data_out(c_dout), .rd_valid(c_rv), .full(c_full), .empty(c_empty),
        .almost_full(c_af), .almost_empty(c_ae), .count(c_cnt),
        .overflow(c_ov), .underflow(c_un)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int nw, nr, mcnt;
    logic wacc, racc;

    initial begin
        // ---------------- reset state ----------------
        #3;
        check("rst_a_cnt",   a_cnt,   0);
        check("rst_a_empty", a_empty, 1);
        check("rst_a_full",  a_full,  0);
        check("rst_a_ae",    a_ae,    1);
        check("rst_a_af",    a_af,    0);
        check("rst_a_ov",    a_ov,    0);
        check("rst_a_un",    a_un,    0);
        check("rst_a_dout",  a_dout,  0);
        check("rst_a_rv",    a_rv,    0);
        check("rst_c_dout",  c_dout,  0);
        check("rst_c_rv",    c_rv,    0);
        check("rst_b_empty", b_empty, 1);
        tick();
        #2 rst_n = 1'b1;
        tick();

        // ---------------- 1: fill 0x01..0x08, read back ----------------
        for (int i = 1; i <= 8; i++) begin
            a_wr = 1; a_din = 8'(i);
            tick();
            check("t1_cnt",   a_cnt, 32'(i));
            check("t1_af",    a_af,  32'(i >= 6));
            check("t1_ae",    a_ae,  32'(i <= 2));
            check("t1_full",  a_full, 32'(i == 8));
            check("t1_rv",    a_rv,  0);
        end
        a_wr = 0;
        for (int i = 1; i <= 8; i++) begin
            a_rd = 1;
            tick();
            check("t1_rd_rv",   a_rv,   1);
            check("t1_rd_data", a_dout, 32'(i));
            check("t1_rd_cnt",  a_cnt,  32'(8 - i));
        end
        a_rd = 0;
        tick();
        check("t1_rv_low",  a_rv,    0);
        check("t1_empty",   a_empty, 1);
        check("t1_hold",    a_dout,  8'h08);
        check("t1_no_un",   a_un,    0);

        // ---------------- 2: overflow on full ----------------
        for (int i = 1; i <= 8; i++) begin
            a_wr = 1; a_din = 8'(8'h10 + i);
            tick();
        end
        a_din = 8'hAA;
        tick();
        check("t2_cnt8",   a_cnt,  8);
        check("t2_ov_set", a_ov,   1);
        check("t2_full",   a_full, 1);
        // write while full with a simultaneous read is still rejected
        a_din = 8'hBB; a_rd = 1;
        tick();
        check("t2_wr_rd_cnt",  a_cnt,  7);
        check("t2_wr_rd_data", a_dout, 8'h11);
        a_wr = 0; a_rd = 0;
        tick();
        check("t2_ov_sticky", a_ov, 1);
        a_clr = 1;
        tick();
        a_clr = 0;
        check("t2_ov_clr", a_ov, 0);
        for (int i = 2; i <= 8; i++) begin
            a_rd = 1;
            tick();
            check("t2_drain", a_dout, 32'(8'h10 + i));
        end
        a_rd = 0;
        tick();
        check("t2_empty", a_empty, 1);

        // ---------------- 3: underflow, simultaneous wr/rd across wrap ----------------
        a_rd = 1;
        tick();
        a_rd = 0;
        check("t3_un",  a_un,  1);
        check("t3_rv",  a_rv,  0);
        check("t3_cnt", a_cnt, 0);
        a_rd = 1; a_clr = 1;
        tick();
        check("t3_set_wins", a_un, 1);
        a_rd = 0;
        tick();
        a_clr = 0;
        check("t3_un_clr", a_un, 0);
        for (int i = 0; i < 4; i++) begin
            a_wr = 1; a_din = 8'(8'h30 + i);
            tick();
        end
        check("t3_cnt4", a_cnt, 4);
        for (int k = 0; k < 10; k++) begin
            a_wr = 1; a_rd = 1; a_din = 8'(8'h34 + k);
            tick();
            check("t3_both_cnt",  a_cnt,  4);
            check("t3_both_rv",   a_rv,   1);
            check("t3_both_data", a_dout, 32'(8'h30 + k));
        end
        a_wr = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t3_tail", a_dout, 32'(8'h3A + k));
        end
        a_rd = 0;
        tick();
        check("t3_empty", a_empty, 1);
        check("t3_ov",    a_ov,    0);

        // ---------------- 6a: flush with wr_en ----------------
        for (int i = 0; i < 5; i++) begin
            a_wr = 1; a_din = 8'(8'h40 + i);
            tick();
        end
        check("t6_cnt5", a_cnt, 5);
        a_flush = 1; a_din = 8'hEE; a_rd = 1;
        tick();
        a_flush = 0; a_wr = 0; a_rd = 0;
        check("t6_cnt0",  a_cnt,   0);
        check("t6_empty", a_empty, 1);
        check("t6_rv",    a_rv,    0);
        check("t6_hold",  a_dout,  8'h3D);
        check("t6_ov",    a_ov,    0);
        tick();
        check("t6_still0", a_cnt, 0);
        a_wr = 1; a_din = 8'h50;
        tick();
        a_wr = 0; a_rd = 1;
        tick();
        a_rd = 0;
        check("t6_post_data", a_dout, 8'h50);
        check("t6_post_cnt",  a_cnt,  0);

        // ---------------- 6b: asynchronous reset mid-burst ----------------
        for (int i = 0; i < 3; i++) begin
            a_wr = 1; a_din = 8'(8'h60 + i);
            tick();
        end
        a_rd = 1; a_din = 8'h63;
        tick();
        check("t6_pre_rv", a_rv, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_cnt",   a_cnt,   0);
        check("t6_rst_empty", a_empty, 1);
        check("t6_rst_ae",    a_ae,    1);
        check("t6_rst_rv",    a_rv,    0);
        check("t6_rst_dout",  a_dout,  0);
        a_wr = 0; a_rd = 0;
        #1 rst_n = 1'b1;
        tick();
        check("t6_after_cnt", a_cnt, 0);

        // ---------------- 4: DEPTH=6, 20 words across wraps ----------------
        nw = 0; nr = 0; mcnt = 0;
        for (int c = 0; c < 300 && nr < 20; c++) begin
            b_wr = (nw < 20) && ((c < 8) || (c % 3 != 0));
            b_rd = (c >= 8) && (c % 2 == 0);
            b_din = 8'(8'h80 + nw);
            wacc = b_wr && (mcnt < 6);
            racc = b_rd && (mcnt > 0);
            tick();
            if (wacc) nw++;
            if (racc) begin
                check("t4_rv",   b_rv,   1);
                check("t4_data", b_dout, 32'(8'h80 + nr));
                nr++;
            end else begin
                check("t4_rv0", b_rv, 0);
            end
            mcnt = mcnt + int'(wacc) - int'(racc);
            check("t4_cnt",  b_cnt,  32'(mcnt));
            check("t4_full", b_full, 32'(mcnt == 6));
        end
        b_wr = 0; b_rd = 0;
        check("t4_all_read", 32'(nr), 20);

        // ---------------- 5: FWFT ----------------
        c_wr = 1; c_din = 8'h55;
        tick();
        c_wr = 0;
        check("t5_dout", c_dout, 8'h55);
        check("t5_rv",   c_rv,   1);
        tick();
        check("t5_hold", c_dout, 8'h55);
        check("t5_cnt",  c_cnt,  1);
        c_rd = 1;
        tick();
        c_rd = 0;
        check("t5_empty", c_empty, 1);
        check("t5_rv0",   c_rv,    0);
        c_wr = 1; c_din = 8'h66;
        tick();
        c_din = 8'h77;
        tick();
        c_wr = 0;
        check("t5_head1", c_dout, 8'h66);
        c_rd = 1;
        tick();
        check("t5_head2", c_dout, 8'h77);
        check("t5_rv2",   c_rv,   1);
        tick();
        c_rd = 0;
        check("t5_empty2", c_empty, 1);
        check("t5_un",     c_un,    0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
